// File: rtl/boa_amo_pkg.sv
// Shared types and helpers for the Boa multi-hart LR/SC reservation controller.
package boa_amo_pkg;

    // Default reservation lifetime in cycles (0 disables expiry).
    localparam int BOA_AMO_TIMEOUT_DEFAULT = 64;

    // Largest hart count the round-robin helper is sized for.
    localparam int BOA_AMO_MAX_CPUS = 16;

    // Widest word address and age counter any configuration can use.
    localparam int BOA_AMO_AW_MAX    = 62;
    localparam int BOA_AMO_AGE_W_MAX = 32;

    // Canonical view of one hart's reservation, sized for the widest build.
    typedef struct packed {
        logic [BOA_AMO_AW_MAX-1:0]    addr;
        logic                         valid;
        logic [BOA_AMO_AGE_W_MAX-1:0] age;
    } boa_amo_resv_t;

    // Index of the first set bit of req at or after ptr, searching upward
    // with wrap-around over n entries; returns n when req is empty.
    function automatic int boa_rr_pick(input logic [BOA_AMO_MAX_CPUS-1:0] req,
                                       input logic [3:0]                  ptr,
                                       input int                          n);
        int  idx;
        int  result;
        bit  found;
        result = n;
        found  = 1'b0;
        for (int i = 0; i < BOA_AMO_MAX_CPUS; i++) begin
            if (i < n && !found) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx[3:0]]) begin
                    result = idx;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/boa_amo_resv_slot.sv
// One hart's reservation: word address, valid flag and age counter.
// Update precedence each cycle is SC, then LR, then kill, then expiry.
module boa_amo_resv_slot
    import boa_amo_pkg::*;
#(
    parameter int aw      = 30,
    parameter int timeout = BOA_AMO_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sc,
    input  logic          lr,
    input  logic [aw-1:0] lr_addr,
    input  logic          lr_kill,
    input  logic          kill,
    output logic          valid,
    output logic [aw-1:0] addr
);

    localparam bit AGE_EN = (timeout > 0);
    localparam int AGE_W  = AGE_EN ? $clog2(timeout + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_EN ? AGE_W'(timeout - 1) : '0;

    logic [AGE_W-1:0] age;

    // Reservation state update: SC drops it, LR (re)arms it, kills and expiry clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            age   <= '0;
        end else if (sc) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (lr) begin
            addr  <= lr_addr;
            valid <= !lr_kill;
            age   <= '0;
        end else if (kill) begin
            valid <= 1'b0;
            age   <= '0;
        end else if (AGE_EN && valid) begin
            if (age == AGE_LAST) begin
                valid <= 1'b0;
                age   <= '0;
            end else begin
                age <= age + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/boa_amo_resv_ctl.sv
// Multi-reservation LR/SC controller: one reservation per hart, snoops
// committed stores, and resolves same-word SC races with a round-robin pointer.
module boa_amo_resv_ctl
    import boa_amo_pkg::*;
#(
    parameter int cpus    = 2,
    parameter int alen    = 32,
    parameter int timeout = BOA_AMO_TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [cpus-1:0]            lr_req,
    input  logic [cpus*(alen-2)-1:0]   lr_addr,
    input  logic [cpus-1:0]            sc_req,
    input  logic [cpus*(alen-2)-1:0]   sc_addr,
    output logic [cpus-1:0]            sc_ok,
    input  logic [cpus-1:0]            wr_snoop,
    input  logic [cpus*(alen-2)-1:0]   wr_addr,
    output logic [cpus-1:0]            resv_valid
);

    localparam int aw    = alen - 2;
    localparam int PTR_W = $clog2(cpus);

    logic [aw-1:0]    lr_a      [cpus];
    logic [aw-1:0]    sc_a      [cpus];
    logic [aw-1:0]    wr_a      [cpus];
    logic [aw-1:0]    slot_addr [cpus];
    logic [cpus-1:0]  peers     [cpus];

    logic [cpus-1:0]  slot_valid;
    logic [cpus-1:0]  foreign_hit;
    logic [cpus-1:0]  cand;
    logic [cpus-1:0]  grant;
    logic [cpus-1:0]  contested;
    logic [cpus-1:0]  kill;
    logic [cpus-1:0]  lr_kill;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_nxt;

    genvar gx;
    generate
        for (gx = 0; gx < cpus; gx++) begin : g_slot
            assign lr_a[gx] = lr_addr[gx*aw +: aw];
            assign sc_a[gx] = sc_addr[gx*aw +: aw];
            assign wr_a[gx] = wr_addr[gx*aw +: aw];

            boa_amo_resv_slot #(
                .aw      (aw),
                .timeout (timeout)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .sc      (sc_req[gx]),
                .lr      (lr_req[gx]),
                .lr_addr (lr_a[gx]),
                .lr_kill (lr_kill[gx]),
                .kill    (kill[gx]),
                .valid   (slot_valid[gx]),
                .addr    (slot_addr[gx])
            );
        end
    endgenerate

    assign resv_valid = slot_valid;

    // A slot is hit by another hart's plain store to its word; an SC that survives this is a candidate.
    always_comb begin
        foreign_hit = '0;
        cand        = '0;
        for (int x = 0; x < cpus; x++) begin
            for (int y = 0; y < cpus; y++) begin
                if (y != x && wr_snoop[y] && wr_a[y] == slot_addr[x]) begin
                    foreign_hit[x] = 1'b1;
                end
            end
        end
        for (int x = 0; x < cpus; x++) begin
            cand[x] = sc_req[x] && slot_valid[x] && (sc_a[x] == slot_addr[x]) && !foreign_hit[x];
        end
    end

    // Group candidates by SC word; within each group the round-robin pick is the only winner.
    always_comb begin
        grant     = '0;
        contested = '0;
        for (int x = 0; x < cpus; x++) begin
            peers[x] = '0;
            for (int y = 0; y < cpus; y++) begin
                if (cand[y] && sc_a[y] == sc_a[x]) begin
                    peers[x][y] = 1'b1;
                end
            end
        end
        for (int x = 0; x < cpus; x++) begin
            grant[x]     = cand[x] && (boa_rr_pick(BOA_AMO_MAX_CPUS'(peers[x]), 4'(rr_ptr), cpus) == x);
            contested[x] = cand[x] && ($countones(peers[x]) > 1);
        end
    end

    // Kills from other harts' stores and granted SCs, against the held address and the incoming LR address.
    always_comb begin
        kill    = '0;
        lr_kill = '0;
        for (int x = 0; x < cpus; x++) begin
            kill[x] = foreign_hit[x];
            for (int y = 0; y < cpus; y++) begin
                if (y != x) begin
                    if (grant[y] && sc_a[y] == slot_addr[x]) begin
                        kill[x] = 1'b1;
                    end
                    if ((wr_snoop[y] && wr_a[y] == lr_a[x]) || (grant[y] && sc_a[y] == lr_a[x])) begin
                        lr_kill[x] = 1'b1;
                    end
                end
            end
        end
    end

    // Pointer moves past the winner of a contested race only; lowest contested winner decides.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        for (int x = cpus - 1; x >= 0; x--) begin
            if (grant[x] && contested[x]) begin
                rr_ptr_nxt = (x == cpus - 1) ? '0 : PTR_W'(x + 1);
            end
        end
    end

    // Registered SC result and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_ok  <= '0;
            rr_ptr <= '0;
        end else begin
            sc_ok  <= grant;
            rr_ptr <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_boa_amo_resv_ctl.sv
// Directed, table-driven bench for the LR/SC reservation controller (4 harts, timeout 8).
module tb_boa_amo_resv_ctl;

    localparam int CPUS = 4;
    localparam int ALEN = 32;
    localparam int AW   = ALEN - 2;
    localparam int TMO  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [CPUS-1:0]      lr_req;
    logic [CPUS*AW-1:0]   lr_addr;
    logic [CPUS-1:0]      sc_req;
    logic [CPUS*AW-1:0]   sc_addr;
    logic [CPUS-1:0]      sc_ok;
    logic [CPUS-1:0]      wr_snoop;
    logic [CPUS*AW-1:0]   wr_addr;
    logic [CPUS-1:0]      resv_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string           name;
        logic            rst;
        logic [CPUS-1:0] lr;
        logic [AW-1:0]   lra;
        logic [CPUS-1:0] sc;
        logic [AW-1:0]   sca;
        logic [CPUS-1:0] wr;
        logic [AW-1:0]   wra;
        logic [CPUS-1:0] eok;
        logic [CPUS-1:0] ev;
    } vec_t;

    vec_t tbl[$];

    boa_amo_resv_ctl #(
        .cpus    (CPUS),
        .alen    (ALEN),
        .timeout (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lr_req     (lr_req),
        .lr_addr    (lr_addr),
        .sc_req     (sc_req),
        .sc_addr    (sc_addr),
        .sc_ok      (sc_ok),
        .wr_snoop   (wr_snoop),
        .wr_addr    (wr_addr),
        .resv_valid (resv_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic r,
                                input logic [CPUS-1:0] lr, input logic [AW-1:0] lra,
                                input logic [CPUS-1:0] sc, input logic [AW-1:0] sca,
                                input logic [CPUS-1:0] wr, input logic [AW-1:0] wra,
                                input logic [CPUS-1:0] eok, input logic [CPUS-1:0] ev);
        vec_t v;
        v.name = n; v.rst = r;
        v.lr = lr; v.lra = lra;
        v.sc = sc; v.sca = sca;
        v.wr = wr; v.wra = wra;
        v.eok = eok; v.ev = ev;
        return v;
    endfunction

    function automatic vec_t idle(input string n, input logic [CPUS-1:0] eok, input logic [CPUS-1:0] ev);
        return mk(n, 1'b1, 4'b0000, '0, 4'b0000, '0, 4'b0000, '0, eok, ev);
    endfunction

    // Drive one cycle of inputs, then step past the next rising edge.
    task automatic applyStimulus(input vec_t v);
        rst_n    = v.rst;
        lr_req   = v.lr;
        lr_addr  = {CPUS{v.lra}};
        sc_req   = v.sc;
        sc_addr  = {CPUS{v.sca}};
        wr_snoop = v.wr;
        wr_addr  = {CPUS{v.wra}};
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string n, input logic [CPUS-1:0] eok, input logic [CPUS-1:0] ev);
        checks++;
        if (sc_ok !== eok) begin
            errors++;
            $display("[TB] FAIL %s sc_ok got %b expected %b", n, sc_ok, eok);
        end
        checks++;
        if (resv_valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s resv_valid got %b expected %b", n, resv_valid, ev);
        end
    endtask

    initial begin
        rst_n = 1'b0; lr_req = '0; lr_addr = '0; sc_req = '0; sc_addr = '0;
        wr_snoop = '0; wr_addr = '0;

        //                name          rst  lr       lra     sc       sca     wr       wra     eok      ev
        tbl.push_back(mk("reset",       0, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0000));
        tbl.push_back(mk("basic_lr",    1, 4'b0001, 'h100, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0001));
        tbl.push_back(idle("basic_c1",  4'b0000, 4'b0001));
        tbl.push_back(idle("basic_c2",  4'b0000, 4'b0001));
        tbl.push_back(mk("basic_sc",    1, 4'b0000, 'h000, 4'b0001, 'h100, 4'b0000, 'h000, 4'b0001, 4'b0000));
        tbl.push_back(idle("basic_pulse", 4'b0000, 4'b0000));
        tbl.push_back(mk("fk_lr",       1, 4'b0001, 'h100, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0001));
        tbl.push_back(idle("fk_c1",     4'b0000, 4'b0001));
        tbl.push_back(mk("fk_hit_sc",   1, 4'b0000, 'h000, 4'b0001, 'h100, 4'b0010, 'h100, 4'b0000, 4'b0000));
        tbl.push_back(mk("fk2_lr",      1, 4'b0001, 'h100, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0001));
        tbl.push_back(idle("fk2_c1",    4'b0000, 4'b0001));
        tbl.push_back(mk("fk_miss_sc",  1, 4'b0000, 'h000, 4'b0001, 'h100, 4'b0010, 'h104, 4'b0001, 4'b0000));
        tbl.push_back(mk("own_lr",      1, 4'b0100, 'h150, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0100));
        tbl.push_back(mk("own_store",   1, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0100, 'h150, 4'b0000, 4'b0100));
        tbl.push_back(mk("own_sc",      1, 4'b0000, 'h000, 4'b0100, 'h150, 4'b0000, 'h000, 4'b0100, 4'b0000));
        tbl.push_back(mk("race1_lr",    1, 4'b1010, 'h200, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b1010));
        tbl.push_back(idle("race1_c1",  4'b0000, 4'b1010));
        tbl.push_back(mk("race1_sc",    1, 4'b0000, 'h000, 4'b1010, 'h200, 4'b0000, 'h000, 4'b0010, 4'b0000));
        tbl.push_back(mk("race2_lr",    1, 4'b1010, 'h200, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b1010));
        tbl.push_back(mk("race2_sc",    1, 4'b0000, 'h000, 4'b1010, 'h200, 4'b0000, 'h000, 4'b1000, 4'b0000));
        tbl.push_back(mk("badaddr_lr",  1, 4'b0001, 'h300, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0001));
        tbl.push_back(mk("badaddr_sc",  1, 4'b0000, 'h000, 4'b0001, 'h304, 4'b0000, 'h000, 4'b0000, 4'b0000));
        tbl.push_back(mk("lrsc_lr",     1, 4'b0001, 'h100, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0001));
        tbl.push_back(mk("lrsc_both",   1, 4'b0001, 'h300, 4'b0001, 'h100, 4'b0000, 'h000, 4'b0001, 4'b0000));
        tbl.push_back(idle("lrsc_after", 4'b0000, 4'b0000));
        tbl.push_back(mk("lr_killed",   1, 4'b0001, 'h400, 4'b0000, 'h000, 4'b0010, 'h400, 4'b0000, 4'b0000));
        tbl.push_back(mk("sck_lr",      1, 4'b0110, 'h500, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0110));
        tbl.push_back(mk("sck_sc",      1, 4'b0000, 'h000, 4'b0010, 'h500, 4'b0000, 'h000, 4'b0010, 4'b0000));
        tbl.push_back(mk("rst_lr",      1, 4'b1001, 'h600, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b1001));
        tbl.push_back(mk("rst_mid",     0, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0000));
        tbl.push_back(mk("rst_sc",      1, 4'b0000, 'h000, 4'b1001, 'h600, 4'b0000, 'h000, 4'b0000, 4'b0000));

        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i].name, tbl[i].eok, tbl[i].ev);
        end

        // Reservation lives exactly timeout cycles: SC on the last valid cycle passes.
        applyStimulus(mk("tmo_pass_lr", 1, 4'b0001, 'h700, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0001));
        checkOutput("tmo_pass_lr", 4'b0000, 4'b0001);
        for (int k = 0; k < TMO - 1; k++) begin
            applyStimulus(idle("tmo_pass_hold", 4'b0000, 4'b0001));
            checkOutput("tmo_pass_hold", 4'b0000, 4'b0001);
        end
        applyStimulus(mk("tmo_pass_sc", 1, 4'b0000, 'h000, 4'b0001, 'h700, 4'b0000, 'h000, 4'b0001, 4'b0000));
        checkOutput("tmo_pass_sc", 4'b0001, 4'b0000);

        // One cycle later the reservation has expired and the SC fails.
        applyStimulus(mk("tmo_fail_lr", 1, 4'b0001, 'h700, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0001));
        checkOutput("tmo_fail_lr", 4'b0000, 4'b0001);
        for (int k = 0; k < TMO - 1; k++) begin
            applyStimulus(idle("tmo_fail_hold", 4'b0000, 4'b0001));
            checkOutput("tmo_fail_hold", 4'b0000, 4'b0001);
        end
        applyStimulus(idle("tmo_fall", 4'b0000, 4'b0000));
        checkOutput("tmo_fall", 4'b0000, 4'b0000);
        applyStimulus(mk("tmo_fail_sc", 1, 4'b0000, 'h000, 4'b0001, 'h700, 4'b0000, 'h000, 4'b0000, 4'b0000));
        checkOutput("tmo_fail_sc", 4'b0000, 4'b0000);

        // A second LR restarts the age, so the SC outlives the first LR's window.
        applyStimulus(mk("rearm_lr1", 1, 4'b0010, 'h800, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0010));
        checkOutput("rearm_lr1", 4'b0000, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(idle("rearm_hold1", 4'b0000, 4'b0010));
            checkOutput("rearm_hold1", 4'b0000, 4'b0010);
        end
        applyStimulus(mk("rearm_lr2", 1, 4'b0010, 'h880, 4'b0000, 'h000, 4'b0000, 'h000, 4'b0000, 4'b0010));
        checkOutput("rearm_lr2", 4'b0000, 4'b0010);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(idle("rearm_hold2", 4'b0000, 4'b0010));
            checkOutput("rearm_hold2", 4'b0000, 4'b0010);
        end
        applyStimulus(mk("rearm_sc", 1, 4'b0000, 'h000, 4'b0010, 'h880, 4'b0000, 'h000, 4'b0010, 4'b0000));
        checkOutput("rearm_sc", 4'b0010, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
